// File: rtl/n_bit_adder_pkg.sv
// n_bit_adder_pkg: shared default width for the adder slice
package n_bit_adder_pkg;
  localparam int ADDER_DEFAULT_W = 8;
endpackage

// File: rtl/n_bit_adder_full_adder.sv
// full_adder: 1-bit full adder cell for the ripple chain
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/n_bit_adder.sv
// n_bit_adder: registered N-bit ripple-carry adder, {carry,sum} = a + b + cin
module n_bit_adder
  import n_bit_adder_pkg::*;
#(
  parameter int N = ADDER_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry
);
  logic [N:0]   c;
  logic [N-1:0] s;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  always_ff @(posedge clk)
    if (rst) {carry, sum} <= '0;
    else     {carry, sum} <= {c[N], s};
endmodule

// File: tb/tb_n_bit_adder.sv
// tb_n_bit_adder: table-driven and sweep checks of n_bit_adder at N=8, 1 and 16
module tb_n_bit_adder;
  typedef struct {
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [7:0]  a8 = 0, b8 = 0, sum8;
  logic        cin8 = 0, carry8;
  logic [0:0]  a1 = 0, b1 = 0, sum1;
  logic        cin1 = 0, carry1;
  logic [15:0] a16 = 0, b16 = 0, sum16;
  logic        cin16 = 0, carry16;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  n_bit_adder #(.N(8))  u8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .cin(cin8),  .sum(sum8),  .carry(carry8));
  n_bit_adder #(.N(1))  u1  (.clk(clk), .rst(rst), .a(a1),  .b(b1),  .cin(cin1),  .sum(sum1),  .carry(carry1));
  n_bit_adder #(.N(16)) u16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .carry(carry16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    vec_t v[7];
    logic [8:0] exp;
    v[0] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b0};
    v[1] = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    v[2] = '{1'b0, 8'd3,  8'd4,  1'b0, 8'd7,  1'b0};
    v[3] = '{1'b0, 8'd3,  8'd4,  1'b1, 8'd8,  1'b0};
    v[4] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    v[5] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

    a1 = 1; b1 = 1; cin1 = 1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 0;
    for (int i = 0; i < 7; i++) begin
      rst = v[i].rst; a8 = v[i].a; b8 = v[i].b; cin8 = v[i].cin;
      step();
      chk($sformatf("vec%0d", i), {8'h0, carry8, sum8}, {8'h0, v[i].carry, v[i].sum});
      if (i == 0) begin
        chk("rst_n1", {15'h0, carry1, sum1}, 17'h0);
        chk("rst_n16", {carry16, sum16}, 17'h0);
      end
      if (i == 1) begin
        chk("n1_max", {15'h0, carry1, sum1}, 17'h3);
        chk("n16_wrap", {carry16, sum16}, 17'h10000);
        a1 = 1; b1 = 0; cin1 = 0; a16 = 16'd3; b16 = 16'd4; cin16 = 1;
      end
      if (i == 2) begin
        chk("n1_basic", {15'h0, carry1, sum1}, 17'h1);
        chk("n16_basic", {carry16, sum16}, 17'd8);
      end
    end

    for (int t = 0; t < 8192; t++) begin
      a8 = t[7:0]; b8 = t[11:4]; cin8 = t[8];
      rst = (t == 3000 || t == 3001);
      exp = rst ? 9'h0 : {1'b0, a8} + {1'b0, b8} + {8'h0, cin8};
      step();
      chk($sformatf("sweep%0d", t), {8'h0, carry8, sum8}, {8'h0, exp});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
